// File: rtl/rv64_alu_pkg.sv
// Shared ALU control, opcode and immediate-format definitions for the RV64 issue stage.
package rv64_alu_pkg;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b10000;
   localparam logic [4:0] ALU_AND  = 5'b00001;
   localparam logic [4:0] ALU_OR   = 5'b00010;
   localparam logic [4:0] ALU_XOR  = 5'b00011;
   localparam logic [4:0] ALU_SLL  = 5'b00100;
   localparam logic [4:0] ALU_SRL  = 5'b00101;
   localparam logic [4:0] ALU_SRA  = 5'b10110;
   localparam logic [4:0] ALU_SLT  = 5'b11111;
   localparam logic [4:0] ALU_SLTU = 5'b10111;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP32      = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   typedef struct packed {
      logic [4:0]  alu_ctr;
      logic        word_op;
      logic [63:0] src1;
      logic [63:0] src2;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        branch;
      logic        jump;
      logic [2:0]  funct3;
   } issue_t;

endpackage

// File: rtl/rv64_imm_gen.sv
// Combinational RV64 immediate generator: I/S/B/U/J forms sign-extended to 64 bits.
module rv64_imm_gen
   import rv64_alu_pkg::*;
(
   input  logic [31:0] inst,
   input  imm_fmt_e    fmt,
   output logic [63:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
         IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/rv64_alu_issue.sv
// RV64I decode/issue stage: one registered slot with valid/ready toward EX.
// Define RV64_ISSUE_ILLEGAL_CHECK_EN to register out_illegal for unlisted encodings.
module rv64_alu_issue
   import rv64_alu_pkg::*;
#(
   parameter int unsigned XLEN         = 64,
   parameter logic [63:0] RESET_PC_SRC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_alu_ctr,
   output logic            out_word_op,
   output logic [XLEN-1:0] out_src1,
   output logic [XLEN-1:0] out_src2,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic            out_rd_wen,
   output logic            out_branch,
   output logic            out_jump,
   output logic [2:0]      out_funct3,
   output logic            out_illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [63:0] imm;
   logic [63:0] shamt;
   imm_fmt_e    fmt;
   logic        legal;
   logic        accept;
   issue_t      dec;
   issue_t      issue_d, issue_q;
   logic        valid_d, valid_q;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign shamt  = {58'b0, in_inst[25:20]};

   rv64_imm_gen u_imm_gen (
      .inst (in_inst),
      .fmt  (fmt),
      .imm  (imm)
   );

   always_comb begin
      fmt         = IMM_I;
      legal       = 1'b0;
      dec         = '0;
      dec.src1    = in_rs1_data;
      dec.src2    = in_rs2_data;
      dec.rd      = in_inst[11:7];
      dec.funct3  = funct3;
      case (opcode)
         OPC_OP: begin
            legal       = 1'b1;
            dec.rd_wen  = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: dec.alu_ctr = ALU_ADD;
               {7'b0100000, 3'b000}: dec.alu_ctr = ALU_SUB;
               {7'b0000000, 3'b001}: dec.alu_ctr = ALU_SLL;
               {7'b0000000, 3'b010}: dec.alu_ctr = ALU_SLT;
               {7'b0000000, 3'b011}: dec.alu_ctr = ALU_SLTU;
               {7'b0000000, 3'b100}: dec.alu_ctr = ALU_XOR;
               {7'b0000000, 3'b101}: dec.alu_ctr = ALU_SRL;
               {7'b0100000, 3'b101}: dec.alu_ctr = ALU_SRA;
               {7'b0000000, 3'b110}: dec.alu_ctr = ALU_OR;
               {7'b0000000, 3'b111}: dec.alu_ctr = ALU_AND;
               default:              legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            legal       = 1'b1;
            dec.rd_wen  = 1'b1;
            dec.src2    = imm;
            case (funct3)
               3'b000: dec.alu_ctr = ALU_ADD;
               3'b010: dec.alu_ctr = ALU_SLT;
               3'b011: dec.alu_ctr = ALU_SLTU;
               3'b100: dec.alu_ctr = ALU_XOR;
               3'b110: dec.alu_ctr = ALU_OR;
               3'b111: dec.alu_ctr = ALU_AND;
               3'b001: begin
                  dec.alu_ctr = ALU_SLL;
                  dec.src2    = shamt;
                  legal       = (in_inst[31:26] == 6'b000000);
               end
               default: begin
                  dec.alu_ctr = in_inst[30] ? ALU_SRA : ALU_SRL;
                  dec.src2    = shamt;
                  legal       = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
               end
            endcase
         end
         OPC_OP32: begin
            legal       = 1'b1;
            dec.rd_wen  = 1'b1;
            dec.word_op = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: dec.alu_ctr = ALU_ADD;
               {7'b0100000, 3'b000}: dec.alu_ctr = ALU_SUB;
               {7'b0000000, 3'b001}: dec.alu_ctr = ALU_SLL;
               {7'b0000000, 3'b101}: dec.alu_ctr = ALU_SRL;
               {7'b0100000, 3'b101}: dec.alu_ctr = ALU_SRA;
               default:              legal = 1'b0;
            endcase
         end
         OPC_OP_IMM32: begin
            dec.rd_wen  = 1'b1;
            dec.word_op = 1'b1;
            dec.src2    = imm;
            case (funct3)
               3'b000: legal = 1'b1;
               3'b001: begin
                  dec.alu_ctr = ALU_SLL;
                  dec.src2    = shamt;
                  legal       = (funct7 == 7'b0000000);
               end
               3'b101: begin
                  dec.alu_ctr = in_inst[30] ? ALU_SRA : ALU_SRL;
                  dec.src2    = shamt;
                  legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            legal      = 1'b1;
            fmt        = IMM_U;
            dec.rd_wen = 1'b1;
            dec.src1   = '0;
            dec.src2   = imm;
         end
         OPC_AUIPC: begin
            legal      = 1'b1;
            fmt        = IMM_U;
            dec.rd_wen = 1'b1;
            dec.src1   = in_pc;
            dec.src2   = imm;
         end
         OPC_JAL, OPC_JALR: begin
            legal      = (opcode == OPC_JAL) || (funct3 == 3'b000);
            fmt        = (opcode == OPC_JAL) ? IMM_J : IMM_I;
            dec.rd_wen = 1'b1;
            dec.jump   = 1'b1;
            dec.src1   = in_pc;
            dec.src2   = 64'd4;
         end
         OPC_BRANCH: begin
            fmt        = IMM_B;
            dec.branch = 1'b1;
            legal      = (funct3[2:1] != 2'b01);
            case (funct3[2:1])
               2'b00:   dec.alu_ctr = ALU_SUB;
               2'b10:   dec.alu_ctr = ALU_SLT;
               default: dec.alu_ctr = ALU_SLTU;
            endcase
         end
         OPC_LOAD: begin
            legal      = (funct3 != 3'b111);
            dec.rd_wen = 1'b1;
            dec.src2   = imm;
         end
         OPC_STORE: begin
            legal    = ~funct3[2];
            fmt      = IMM_S;
            dec.src2 = imm;
         end
         default: legal = 1'b0;
      endcase
      // Unrecognised encodings collapse to a harmless ADD with no side effects.
      if (!legal) begin
         dec.alu_ctr = ALU_ADD;
         dec.word_op = 1'b0;
         dec.rd_wen  = 1'b0;
         dec.branch  = 1'b0;
         dec.jump    = 1'b0;
      end
      if (dec.rd == 5'd0) dec.rd_wen = 1'b0;
      dec.imm = imm;
   end

   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      issue_d = accept ? dec : issue_q;
      if (flush)          valid_d = 1'b0;
      else if (accept)    valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
      else                valid_d = valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         issue_q      <= '0;
         issue_q.src1 <= RESET_PC_SRC;
         issue_q.src2 <= RESET_PC_SRC;
         issue_q.imm  <= RESET_PC_SRC;
      end else begin
         valid_q <= valid_d;
         issue_q <= issue_d;
      end
   end

`ifdef RV64_ISSUE_ILLEGAL_CHECK_EN
   logic illegal_d, illegal_q;

   always_comb illegal_d = accept ? ~legal : illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   assign out_illegal = illegal_q;
`else
   assign out_illegal = 1'b0;
`endif

   assign out_valid   = valid_q;
   assign out_alu_ctr = issue_q.alu_ctr;
   assign out_word_op = issue_q.word_op;
   assign out_src1    = issue_q.src1;
   assign out_src2    = issue_q.src2;
   assign out_imm     = issue_q.imm;
   assign out_rd      = issue_q.rd;
   assign out_rd_wen  = issue_q.rd_wen;
   assign out_branch  = issue_q.branch;
   assign out_jump    = issue_q.jump;
   assign out_funct3  = issue_q.funct3;

endmodule

// File: tb/tb_rv64_alu_issue.sv
// Directed bench for rv64_alu_issue: decode vectors, backpressure, flush and async reset.
module tb_rv64_alu_issue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, in_rs1_data, in_rs2_data;
   logic [4:0]  out_alu_ctr, out_rd;
   logic        out_word_op, out_rd_wen, out_branch, out_jump, out_illegal;
   logic [63:0] out_src1, out_src2, out_imm;
   logic [2:0]  out_funct3;
   logic        exp_illegal;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   rv64_alu_issue #(.XLEN(64), .RESET_PC_SRC(64'd0)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_ctr (out_alu_ctr),
      .out_word_op (out_word_op),
      .out_src1    (out_src1),
      .out_src2    (out_src2),
      .out_imm     (out_imm),
      .out_rd      (out_rd),
      .out_rd_wen  (out_rd_wen),
      .out_branch  (out_branch),
      .out_jump    (out_jump),
      .out_funct3  (out_funct3),
      .out_illegal (out_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] rs1, input logic [63:0] rs2);
      in_valid    = 1'b1;
      in_inst     = inst;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
`ifdef RV64_ISSUE_ILLEGAL_CHECK_EN
      exp_illegal = 1'b1;
`else
      exp_illegal = 1'b0;
`endif
      #12;
      chk("rst_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_src1", out_src1, 64'd0);
      chk("rst_src2", out_src2, 64'd0);
      chk("rst_imm", out_imm, 64'd0);
      chk("rst_ctr", {59'b0, out_alu_ctr}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      rst = 1'b0;

      // ADDI x1,x2,-1
      drive(32'hFFF10093, 64'h100, 64'd5, 64'd9);
      tick();
      chk("addi_valid", {63'b0, out_valid}, 64'd1);
      chk("addi_ctr", {59'b0, out_alu_ctr}, 64'b00000);
      chk("addi_src1", out_src1, 64'd5);
      chk("addi_src2", out_src2, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_rd", {59'b0, out_rd}, 64'd1);
      chk("addi_wen", {63'b0, out_rd_wen}, 64'd1);
      chk("addi_word", {63'b0, out_word_op}, 64'd0);

      // SUBW x3,x4,x5
      drive(32'h405201BB, 64'h104, 64'h1234, 64'h10);
      tick();
      chk("subw_ctr", {59'b0, out_alu_ctr}, 64'b10000);
      chk("subw_word", {63'b0, out_word_op}, 64'd1);
      chk("subw_src1", out_src1, 64'h1234);
      chk("subw_src2", out_src2, 64'h10);
      chk("subw_rd", {59'b0, out_rd}, 64'd3);

      // SRAI x6,x7,63
      drive(32'h43F3D313, 64'h108, 64'h8000_0000_0000_0000, 64'd0);
      tick();
      chk("srai_ctr", {59'b0, out_alu_ctr}, 64'b10110);
      chk("srai_word", {63'b0, out_word_op}, 64'd0);
      chk("srai_src2", out_src2, 64'd63);
      chk("srai_imm", out_imm, 64'h43F);
      chk("srai_wen", {63'b0, out_rd_wen}, 64'd1);
      chk("srai_illegal", {63'b0, out_illegal}, 64'd0);

      // SRAI with reserved funct6 = 110000
      drive(32'hC3F3D313, 64'h10C, 64'd1, 64'd0);
      tick();
      chk("badsh_ctr", {59'b0, out_alu_ctr}, 64'b00000);
      chk("badsh_wen", {63'b0, out_rd_wen}, 64'd0);
      chk("badsh_illegal", {63'b0, out_illegal}, {63'b0, exp_illegal});

      // BLTU x1,x2
      drive(32'h0020E063, 64'h110, 64'd7, 64'd8);
      tick();
      chk("bltu_ctr", {59'b0, out_alu_ctr}, 64'b10111);
      chk("bltu_branch", {63'b0, out_branch}, 64'd1);
      chk("bltu_wen", {63'b0, out_rd_wen}, 64'd0);
      chk("bltu_funct3", {61'b0, out_funct3}, 64'd6);
      chk("bltu_src2", out_src2, 64'd8);

      // LUI x5,0x80000
      drive(32'h800002B7, 64'h114, 64'd3, 64'd0);
      tick();
      chk("lui_src1", out_src1, 64'd0);
      chk("lui_src2", out_src2, 64'hFFFF_FFFF_8000_0000);

      // JAL x1,+8
      drive(32'h008000EF, 64'h1000, 64'd0, 64'd0);
      tick();
      chk("jal_src1", out_src1, 64'h1000);
      chk("jal_src2", out_src2, 64'd4);
      chk("jal_imm", out_imm, 64'd8);
      chk("jal_jump_wen", {62'b0, out_jump, out_rd_wen}, 64'b11);

      // SW x2,-4(x1)
      drive(32'hFE20AE23, 64'h1004, 64'h2000, 64'h55);
      tick();
      chk("sw_src2", out_src2, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("sw_wen", {63'b0, out_rd_wen}, 64'd0);
      chk("sw_funct3", {61'b0, out_funct3}, 64'd2);

      // ADD x0,x1,x2: write to x0 suppressed
      drive(32'h00208033, 64'h1008, 64'd1, 64'd2);
      tick();
      chk("add_x0_wen", {63'b0, out_rd_wen}, 64'd0);

      // SLT x3,x1,x2
      drive(32'h0020A1B3, 64'h100C, 64'd1, 64'd2);
      tick();
      chk("slt_ctr", {59'b0, out_alu_ctr}, 64'b11111);

      // Unknown opcode
      drive(32'h0000007F, 64'h1010, 64'd1, 64'd2);
      tick();
      chk("unk_ctrl", {55'b0, out_alu_ctr, out_rd_wen, out_branch, out_jump, out_word_op}, 64'd0);
      chk("unk_illegal", {63'b0, out_illegal}, {63'b0, exp_illegal});

      in_valid = 1'b0;
      tick();
      chk("drain_valid", {63'b0, out_valid}, 64'd0);

      // Backpressure: ADDI held while SUBW waits upstream
      out_ready = 1'b0;
      drive(32'hFFF10093, 64'h200, 64'd5, 64'd0);
      tick();
      drive(32'h405201BB, 64'h204, 64'h77, 64'h11);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
         tick();
         chk("bp_valid", {63'b0, out_valid}, 64'd1);
         chk("bp_rd", {59'b0, out_rd}, 64'd1);
         chk("bp_src1", out_src1, 64'd5);
         chk("bp_src2", out_src2, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {63'b0, in_ready}, 64'd1);
      tick();
      chk("bp_nobubble_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_nobubble_rd", {59'b0, out_rd}, 64'd3);
      chk("bp_nobubble_ctr", {59'b0, out_alu_ctr}, 64'b10000);

      // Flush while occupied, with a same-cycle input
      out_ready = 1'b0;
      flush = 1'b1;
      drive(32'hFFF10093, 64'h300, 64'd5, 64'd0);
      tick();
      chk("flush_valid", {63'b0, out_valid}, 64'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("flush_dropped", {63'b0, out_valid}, 64'd0);

      // Asynchronous reset mid-stall
      drive(32'hFFF10093, 64'h400, 64'd5, 64'd0);
      tick();
      chk("ar_loaded", {63'b0, out_valid}, 64'd1);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("ar_valid", {63'b0, out_valid}, 64'd0);
      chk("ar_src1", out_src1, 64'd0);
      chk("ar_src2", out_src2, 64'd0);
      chk("ar_rd_wen", {58'b0, out_rd, out_rd_wen}, 64'd0);
      rst = 1'b0;
      tick();
      chk("ar_after", {63'b0, out_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
